// File: rtl/pwm_multi.sv
// Multi-channel PWM with a shared period counter, edge/centre alignment, per-channel polarity
// and double-buffered period/duty/mode shadows. Define PWM_COMPLEMENT_EN for dead-time complementary outputs.
module pwm_multi #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int DEADTIME = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    input  logic                      center_mode_i,
    input  logic [WIDTH-1:0]          period_i,
    input  logic [CHANNELS*WIDTH-1:0] duty_i,
    input  logic [CHANNELS-1:0]       polarity_i,
    input  logic                      update_i,
    output logic                      update_ack_o,
    output logic                      cycle_start_o,
    output logic [CHANNELS-1:0]       pwm_out_o
`ifdef PWM_COMPLEMENT_EN
    ,
    output logic [CHANNELS-1:0]       pwm_out_n_o
`endif
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [WIDTH-1:0]    cnt_q, cnt_d;
    dir_e                dir_q, dir_d;
    logic                pending_q;
    logic                running_q;
    logic [WIDTH-1:0]    perS_q;
    logic                modeS_q;
    logic [WIDTH-1:0]    dutyS_q [CHANNELS];
    logic                updateAck_q;
    logic                cycleStart_q;
    logic [CHANNELS-1:0] pwmOut_q;

    logic [WIDTH-1:0]    perMax;
    logic                run;
    logic                wrapEvt;
    logic                restartEvt;
    logic                loadNow;
    logic [CHANNELS-1:0] act;

    assign perMax  = perS_q - WIDTH'(1);
    assign run     = enable_i && (perS_q != '0);
    assign loadNow = (wrapEvt || !enable_i || (perS_q == '0)) && (pending_q || update_i);

    // Counter next state; a fresh start after idle counts as a period start but not a load point.
    always_comb begin
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        wrapEvt    = 1'b0;
        restartEvt = 1'b0;
        if (!run) begin
            cnt_d = '0;
            dir_d = DIR_UP;
        end else if (!running_q) begin
            cnt_d      = '0;
            dir_d      = DIR_UP;
            restartEvt = 1'b1;
        end else if (!modeS_q || (perS_q == WIDTH'(1))) begin
            dir_d = DIR_UP;
            if (cnt_q >= perMax) begin
                cnt_d   = '0;
                wrapEvt = 1'b1;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end else if (dir_q == DIR_UP) begin
            if (cnt_q >= perMax) begin
                cnt_d = cnt_q - WIDTH'(1);
                dir_d = DIR_DOWN;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end else begin
            if (cnt_q <= WIDTH'(1)) begin
                cnt_d   = '0;
                dir_d   = DIR_UP;
                wrapEvt = 1'b1;
            end else begin
                cnt_d = cnt_q - WIDTH'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            act[i] = run && (cnt_q < dutyS_q[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q        <= '0;
            dir_q        <= DIR_UP;
            pending_q    <= 1'b0;
            running_q    <= 1'b0;
            perS_q       <= '0;
            modeS_q      <= 1'b0;
            updateAck_q  <= 1'b0;
            cycleStart_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                dutyS_q[i] <= '0;
            end
        end else begin
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            running_q    <= run;
            cycleStart_q <= wrapEvt || restartEvt;
            updateAck_q  <= loadNow;
            pending_q    <= loadNow ? 1'b0 : (pending_q || update_i);
            if (loadNow) begin
                perS_q  <= period_i;
                modeS_q <= center_mode_i;
                for (int i = 0; i < CHANNELS; i++) begin
                    dutyS_q[i] <= duty_i[i*WIDTH +: WIDTH];
                end
            end
        end
    end

`ifdef PWM_COMPLEMENT_EN
    localparam int DTW = (DEADTIME < 2) ? 1 : $clog2(DEADTIME);

    logic [CHANNELS-1:0] loOut_q;
    logic [CHANNELS-1:0] aPrev_q;
    logic [DTW-1:0]      deadCnt_q [CHANNELS];

    // Every change of act restarts the dead window, so pulses shorter than DEADTIME never reach a pin.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pwmOut_q <= '0;
            loOut_q  <= '0;
            aPrev_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                deadCnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!run) begin
                    aPrev_q[i]   <= 1'b0;
                    deadCnt_q[i] <= '0;
                    pwmOut_q[i]  <= polarity_i[i];
                    loOut_q[i]   <= polarity_i[i];
                end else begin
                    aPrev_q[i] <= act[i];
                    if ((DEADTIME != 0) && (act[i] != aPrev_q[i])) begin
                        deadCnt_q[i] <= DTW'(DEADTIME - 1);
                        pwmOut_q[i]  <= polarity_i[i];
                        loOut_q[i]   <= polarity_i[i];
                    end else if (deadCnt_q[i] != '0) begin
                        deadCnt_q[i] <= deadCnt_q[i] - DTW'(1);
                        pwmOut_q[i]  <= polarity_i[i];
                        loOut_q[i]   <= polarity_i[i];
                    end else begin
                        pwmOut_q[i] <= act[i] ^ polarity_i[i];
                        loOut_q[i]  <= ~act[i] ^ polarity_i[i];
                    end
                end
            end
        end
    end

    assign pwm_out_n_o = loOut_q;
`else
    logic unusedDeadtime;
    assign unusedDeadtime = (DEADTIME != 0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pwmOut_q <= '0;
        end else begin
            pwmOut_q <= act ^ polarity_i;
        end
    end
`endif

    assign pwm_out_o     = pwmOut_q;
    assign update_ack_o  = updateAck_q;
    assign cycle_start_o = cycleStart_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: stimulus pushes hand-derived per-cycle expectations,
// a negedge monitor pops and compares them when their cycle comes up.
module tb_pwm_multi;

    localparam int W  = 16;
    localparam int CH = 4;

    logic            clk        = 1'b0;
    logic            rstN       = 1'b0;
    logic            enable     = 1'b0;
    logic            centerMode = 1'b0;
    logic            update     = 1'b0;
    logic [W-1:0]    period     = '0;
    logic [CH*W-1:0] duty       = '0;
    logic [CH-1:0]   polarity   = '0;
    logic            updateAck;
    logic            cycleStart;
    logic [CH-1:0]   pwmOut;
    logic [CH-1:0]   gotN;

    int cyc        = 0;
    int totalCount = 0;
    int badCount   = 0;

    typedef struct {
        int       cyc;
        string    name;
        logic [3:0] pwm;
        logic [3:0] pwmN;
        logic [3:0] mask;
        logic     cs;
        logic     chkCs;
        logic     ack;
    } exp_t;

    exp_t expQ[$];

`ifdef PWM_COMPLEMENT_EN
    logic [CH-1:0] pwmOutN;
    assign gotN = pwmOutN;
`else
    assign gotN = '0;
`endif

    pwm_multi #(.WIDTH(W), .CHANNELS(CH), .DEADTIME(4)) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .enable_i      (enable),
        .center_mode_i (centerMode),
        .period_i      (period),
        .duty_i        (duty),
        .polarity_i    (polarity),
        .update_i      (update),
        .update_ack_o  (updateAck),
        .cycle_start_o (cycleStart),
        .pwm_out_o     (pwmOut)
`ifdef PWM_COMPLEMENT_EN
        ,
        .pwm_out_n_o   (pwmOutN)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic applyStimulus(input string name, input logic [3:0] expPwm, input logic [3:0] expPwmN,
                                 input logic [3:0] mask, input logic expCs, input logic chkCs, input logic expAck);
        exp_t e;
        e.cyc   = cyc + 1;
        e.name  = name;
        e.pwm   = expPwm;
        e.pwmN  = expPwmN;
        e.mask  = mask;
        e.cs    = expCs;
        e.chkCs = chkCs;
        e.ack   = expAck;
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic expectAll(input string name, input logic [3:0] expPwm, input logic expCs, input logic expAck);
        applyStimulus(name, expPwm, 4'b0000, 4'b1111, expCs, 1'b1, expAck);
    endtask

    task automatic checkOutput(input exp_t e);
        logic ok;
        totalCount++;
        ok = ((pwmOut & e.mask) == (e.pwm & e.mask)) && (updateAck == e.ack) && (!e.chkCs || (cycleStart == e.cs));
`ifdef PWM_COMPLEMENT_EN
        ok = ok && ((gotN & e.mask) == (e.pwmN & e.mask));
`endif
        if (!ok) begin
            badCount++;
            $display("[TB] FAIL %s cyc=%0d: got pwm=%b pwm_n=%b cs=%b ack=%b, want pwm=%b pwm_n=%b cs=%b ack=%b mask=%b",
                     e.name, cyc, pwmOut, gotN, cycleStart, updateAck, e.pwm, e.pwmN, e.cs, e.ack, e.mask);
        end
    endtask

    // Monitor: due entries are compared; anything older than the current cycle was skipped.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
                e = expQ.pop_front();
                if (e.cyc < cyc) begin
                    totalCount++;
                    badCount++;
                    $display("[TB] FAIL %s: expectation for cyc %0d never compared (now %0d)", e.name, e.cyc, cyc);
                end else begin
                    checkOutput(e);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        badCount++;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d expectations pending", expQ.size());
        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

    initial begin : stimulus
        logic ch0;
        logic hi;
        logic lo;
        int   p;
        @(posedge clk);
        #1;
`ifndef PWM_COMPLEMENT_EN
        expectAll("reset0", 4'b0000, 1'b0, 1'b0);
        expectAll("reset1", 4'b0000, 1'b0, 1'b0);

        // Load shadows while idle: ch0=3, ch1=0, ch2=10 (>=period), ch3=15 with inverted polarity.
        rstN     = 1'b1;
        period   = 16'd10;
        duty     = {16'd15, 16'd10, 16'd0, 16'd3};
        polarity = 4'b1000;
        update   = 1'b1;
        expectAll("idle_load", 4'b1000, 1'b0, 1'b1);

        // Output at offset j reflects cnt at j-1; offset 0 sees the held cnt=0. Duty 7 requested at cnt=4
        // takes effect only after the wrap that produces offset 40.
        update = 1'b0;
        enable = 1'b1;
        for (int j = 0; j < 64; j++) begin
            if (j == 35) begin
                duty[15:0] = 16'd7;
                update     = 1'b1;
            end else begin
                update = 1'b0;
            end
            if (j == 0) ch0 = 1'b1;
            else if (j < 40) ch0 = (((j - 1) % 10) < 3);
            else ch0 = (((j - 1) % 10) < 7);
            expectAll($sformatf("edge_j%0d", j), {1'b0, 1'b1, 1'b0, ch0}, (j % 10) == 0, j == 40);
        end

        // Disable mid-period (ch0 would be high here) and load centre mode, period 6, duty 2.
        enable     = 1'b0;
        update     = 1'b1;
        centerMode = 1'b1;
        period     = 16'd6;
        duty[15:0] = 16'd2;
        expectAll("disable_load_centre", 4'b1000, 1'b0, 1'b1);

        // cnt runs 0,1,2,3,4,5,4,3,2,1 over 10 clocks; cnt<2 holds at cnt 1,0,1 around each wrap.
        update = 1'b0;
        enable = 1'b1;
        for (int c = 0; c < 30; c++) begin
            ch0 = ((c % 10) <= 2);
            expectAll($sformatf("centre_c%0d", c), {1'b0, 1'b1, 1'b0, ch0}, (c % 10) == 0, 1'b0);
        end

        enable     = 1'b0;
        update     = 1'b1;
        centerMode = 1'b0;
        period     = 16'd0;
        expectAll("load_per0", 4'b1000, 1'b0, 1'b1);
        update = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            expectAll($sformatf("per0_k%0d", k), 4'b1000, 1'b0, 1'b0);
        end

        // A zero period is itself a load point, so this update lands on the very next edge.
        update     = 1'b1;
        period     = 16'd1;
        duty[15:0] = 16'd1;
        expectAll("load_per1", 4'b1000, 1'b0, 1'b1);
        update = 1'b0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus($sformatf("per1_k%0d", k), 4'b0101, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
        end

        enable   = 1'b0;
        polarity = 4'b0011;
        expectAll("disable_pol0", 4'b0011, 1'b0, 1'b0);
        expectAll("disable_pol1", 4'b0011, 1'b0, 1'b0);
`else
        applyStimulus("creset0", 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0);
        applyStimulus("creset1", 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0);
        rstN     = 1'b1;
        period   = 16'd20;
        duty     = {16'd0, 16'd0, 16'd0, 16'd8};
        polarity = 4'b0000;
        update   = 1'b1;
        applyStimulus("cload", 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1);

        // Steady state from offset 20: with p = cnt one clock earlier, high side at p 4..7,
        // low side at p 12..19, both off for 4 clocks after each act edge.
        update = 1'b0;
        enable = 1'b1;
        for (int c = 0; c < 60; c++) begin
            p  = (c + 19) % 20;
            hi = (p >= 4) && (p <= 7);
            lo = (p >= 12);
            applyStimulus($sformatf("comp_c%0d", c), {3'b000, hi}, {3'b000, lo},
                          (c >= 20) ? 4'b0001 : 4'b0000, (c % 20) == 0, 1'b1, 1'b0);
        end

        rstN = 1'b0;
        applyStimulus("creset_mid", 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0);
`endif
        rstN = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (expQ.size() != 0) begin
            totalCount++;
            badCount++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
